popcount_select: RTL and testbench

- Sequential inverse of the team's combinational popcount: given a data vector and a requested count N, it produces a mask of the lowest-indexed N set bits of the vector.
- Invariant: popcount(mask_o) == min(N, popcount(data_i)).
- Used by arbiters and allocators that must grant exactly N of several requesters.
- Valid/ready on both sides; one transaction in flight.

---
 rtl/popcount_select.sv | 144 ++++++++++++++
 tb/tb_popcount_select.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/popcount_select.sv
// rtl/popcount_select.sv - selects the lowest-indexed N set bits of a vector (optional POPCOUNT_SELECT_FAST_SCAN_EN)
module popcount_select #(
    parameter int INPUT_WIDTH = 32,
    parameter int CountWidth  = $clog2(INPUT_WIDTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [INPUT_WIDTH-1:0] data_i,
    input  logic [CountWidth-1:0]  count_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INPUT_WIDTH-1:0] mask_o,
    output logic [CountWidth-1:0]  granted_o,
    output logic                   short_o
);

    if (INPUT_WIDTH < 1) begin : g_width_check
        $error("popcount_select: INPUT_WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] data_q, data_d;
    logic [INPUT_WIDTH-1:0] mask_q, mask_d;
    logic [CountWidth-1:0]  remaining_q, remaining_d;
    logic [CountWidth-1:0]  count_q, count_d;
    logic [CountWidth-1:0]  granted_q, granted_d;
    logic [CountWidth-1:0]  idx_q, idx_d;
    logic                   short_q, short_d;

    logic [INPUT_WIDTH-1:0] pick;
    logic [CountWidth-1:0]  idx_next;
    logic                   last;
    logic                   sel;

`ifdef POPCOUNT_SELECT_FAST_SCAN_EN
    logic                   found;
    logic [CountWidth-1:0]  pos;

    // Descending loop so the lowest set bit at or above idx wins.
    always_comb begin
        found = 1'b0;
        pos   = '0;
        pick  = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (data_q[i] && (CountWidth'(i) >= idx_q)) begin
                found = 1'b1;
                pos   = CountWidth'(i);
            end
        end
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            pick[i] = found && (remaining_q != '0) && (CountWidth'(i) == pos);
        end
        idx_next = pos + CountWidth'(1);
        last     = !found;
    end
`else
    always_comb begin
        pick = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            pick[i] = data_q[i] && (remaining_q != '0) && (CountWidth'(i) == idx_q);
        end
        idx_next = idx_q + CountWidth'(1);
        last     = (idx_q == CountWidth'(INPUT_WIDTH - 1));
    end
`endif

    assign sel = |pick;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mask_d      = mask_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        granted_d   = granted_q;
        idx_d       = idx_q;
        short_d     = short_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    data_d      = data_i;
                    remaining_d = count_i;
                    count_d     = count_i;
                    mask_d      = '0;
                    granted_d   = '0;
                    idx_d       = '0;
                    short_d     = 1'b0;
                    state_d     = (count_i == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                mask_d = mask_q | pick;
                if (sel) begin
                    granted_d   = granted_q + CountWidth'(1);
                    remaining_d = remaining_q - CountWidth'(1);
                end
                idx_d = idx_next;
                if ((sel && (remaining_q == CountWidth'(1))) || last) begin
                    state_d = DONE;
                end
                short_d = (granted_d != count_q);
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            granted_q   <= '0;
            idx_q       <= '0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            granted_q   <= granted_d;
            idx_q       <= idx_d;
            short_q     <= short_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign valid_o   = (state_q == DONE);
    assign mask_o    = mask_q;
    assign granted_o = granted_q;
    assign short_o   = short_q;

endmodule

// File: tb/tb_popcount_select.sv
// tb/tb_popcount_select.sv - scoreboard bench for popcount_select
module tb_popcount_select;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic [5:0]  count_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] mask_o;
    logic [5:0]  granted_o;
    logic        short_o;

    popcount_select dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .count_i  (count_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .mask_o   (mask_o),
        .granted_o(granted_o),
        .short_o  (short_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] mask;
        logic [5:0]  granted;
        logic        sh;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] d, input logic [5:0] c, input logic [31:0] m,
                         input logic [5:0] g, input logic s, input int lat_slow, input int lat_fast);
        exp_t e;
        bit   done;
        done = 0;
        valid_i = 1'b1;
        data_i  = d;
        count_i = c;
        for (int n = 0; n < 200 && !done; n++) begin
            if (ready_o) begin
                e.mask = m;
                e.granted = g;
                e.sh = s;
`ifdef POPCOUNT_SELECT_FAST_SCAN_EN
                e.lat = lat_fast;
`else
                e.lat = lat_slow;
`endif
                e.acc = cyc;
                sb_q.push_back(e);
                done = 1;
                @(posedge clk_i);
                @(negedge clk_i);
                valid_i = 1'b0;
                data_i  = $urandom;
                count_i = 6'h3F;
            end else begin
                @(negedge clk_i);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: request %0h/%0d never accepted", d, c);
            valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        bit   seen;
        seen = 0;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_ni) begin
                seen = 0;
            end else begin
                if (valid_o && !seen) begin
                    seen = 1;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: valid_o=1 expected=no result");
                    end else begin
                        chk("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
                    end
                end
                if (valid_o && ready_i && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("mask", 64'(mask_o), 64'(e.mask));
                    chk("granted", 64'(granted_o), 64'(e.granted));
                    chk("short", 64'(short_o), 64'(e.sh));
                    seen = 0;
                end
            end
        end
    end

    initial begin : stim
        int n;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_mask", 64'(mask_o), 64'd0);
        chk("rst_granted", 64'(granted_o), 64'd0);
        chk("rst_short", 64'(short_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        issue(32'h0000_00F0, 6'd2, 32'h0000_0030, 6'd2, 1'b0, 7, 3);
        issue(32'h8000_0001, 6'd2, 32'h8000_0001, 6'd2, 1'b0, 33, 3);
        issue(32'h0000_0005, 6'd5, 32'h0000_0005, 6'd2, 1'b1, 33, 4);
        issue(32'hFFFF_FFFF, 6'd0, 32'h0000_0000, 6'd0, 1'b0, 1, 1);
        issue(32'h0000_0000, 6'd3, 32'h0000_0000, 6'd0, 1'b1, 33, 2);
        drain();

        // Backpressure: result A held in DONE while request B waits.
        ready_i = 1'b0;
        issue(32'h0000_0300, 6'd1, 32'h0000_0100, 6'd1, 1'b0, 10, 2);
        n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        valid_i = 1'b1;
        data_i  = 32'hA000_0000;
        count_i = 6'd40;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_ready", 64'(ready_o), 64'd0);
            chk("bp_mask", 64'(mask_o), 64'h100);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("post_hs_ready", 64'(ready_o), 64'd1);
        chk("post_hs_valid", 64'(valid_o), 64'd0);
        issue(32'hA000_0000, 6'd40, 32'hA000_0000, 6'd2, 1'b1, 33, 4);
        drain();

        // Reset in the middle of a scan discards the transaction.
        issue(32'hFFFF_FFFF, 6'd20, 32'h000F_FFFF, 6'd20, 1'b0, 21, 21);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_mask", 64'(mask_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd1);
        chk("midrst_granted", 64'(granted_o), 64'd0);
        sb_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        issue(32'h0000_0F00, 6'd3, 32'h0000_0700, 6'd3, 1'b0, 12, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
